tmds_encoder_multi: RTL

//  NCHAN-lane HDMI/DVI TMDS encoder, successor to the single-lane encoder. Maps per-lane 8b pixel,
//  2b control or 4b TERC4 aux data to 10b symbols. Sits between the video/packet framer and the
//  10:1 serialisers. Adds: lane count parameter, clock-enable pipeline, fill flag, disparity clear

---
 rtl/tmds_pkg.sv | 49 ++++
 rtl/tmds_lane_enc.sv | 163 ++++++++++++++++
 rtl/tmds_encoder_multi.sv | 93 +++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tmds_pkg                                                        |
// | Purpose  : Shared symbol types, fixed TMDS code tables and bit helpers     |
// |            for the multi-lane TMDS encoder.                                |
// | Options  : TMDS_DISP_MON_EN (used by importers; nothing here depends on it)|
// | Revision : 1.0  initial multi-lane release                                 |
// +----------------------------------------------------------------------------+
package tmds_pkg;

  // Symbol type carried alongside every lane's data
  localparam logic [1:0] DT_GUARD = 2'b00;
  localparam logic [1:0] DT_CTRL  = 2'b01;
  localparam logic [1:0] DT_AUX   = 2'b10;
  localparam logic [1:0] DT_PIX   = 2'b11;

  // Control period words, indexed by {c1,c0}; written as q_out[9:0]
  localparam logic [9:0] CTRL_WORDS [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  // TERC4 data-island words, indexed by the aux nibble
  localparam logic [9:0] TERC4_WORDS [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Guard band words; lane 1 uses the complementary pattern
  localparam logic [9:0] GUARD_WORDS [4] = '{
    10'b1011001100, 10'b0100110011, 10'b1011001100, 10'b1011001100
  };

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [9:0] bitrev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[9-i] = v[i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_lane_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tmds_lane_enc                                                   |
// | Purpose  : One TMDS lane: 3-stage clock-enabled encoder (q_m, balanced /   |
// |            ctl / TERC4 words with running disparity, final mux + order).   |
// | Options  : TMDS_DISP_MON_EN adds disp_o (running disparity, S3-aligned)    |
// | Revision : 1.0  initial multi-lane release                                 |
// +----------------------------------------------------------------------------+
module tmds_lane_enc
  import tmds_pkg::*;
#(
  parameter int LANE        = 0,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ce_i,
  input  logic [1:0]        dtype_i,
  input  logic [1:0]        ctl_i,
  input  logic [3:0]        aux_i,
  input  logic [7:0]        data_i,
  output logic [9:0]        word_o
`ifdef TMDS_DISP_MON_EN
  ,
  output logic signed [4:0] disp_o
`endif
);

  localparam logic [1:0] LANE_IDX   = 2'(LANE);
  localparam logic [9:0] GUARD_WORD = GUARD_WORDS[LANE_IDX];
  localparam logic [9:0] RESET_WORD = BIT_REVERSE ? bitrev10(CTRL_WORDS[2'd0])
                                                  : CTRL_WORDS[2'd0];

  // ---------------- S1 ----------------
  logic [3:0] data_ones;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [1:0] dtype1_q;
  logic [1:0] ctl1_q;
  logic [3:0] aux1_q;
  logic [8:0] qm1_q;

  // Transition-minimised q_m: XNOR chain when the byte is ones-heavy
  always_comb begin
    data_ones = popcount8(data_i);
    use_xnor  = (data_ones > 4'd4) || ((data_ones == 4'd4) && !data_i[0]);
    qm_d      = 9'd0;
    qm_d[0]   = data_i[0];
    for (int b = 1; b < 8; b++) begin
      qm_d[b] = use_xnor ? ~(qm_d[b-1] ^ data_i[b]) : (qm_d[b-1] ^ data_i[b]);
    end
    qm_d[8] = ~use_xnor;
  end

  // S1 registers; reset loads a ctl-00 symbol so the pipe drains to the idle word
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dtype1_q <= DT_CTRL;
      ctl1_q   <= 2'b00;
      aux1_q   <= 4'd0;
      qm1_q    <= 9'd0;
    end else if (ce_i) begin
      dtype1_q <= dtype_i;
      ctl1_q   <= ctl_i;
      aux1_q   <= aux_i;
      qm1_q    <= qm_d;
    end
  end

  // ---------------- S2 ----------------
  logic [3:0]        n1;
  logic [3:0]        n0;
  logic signed [5:0] diff;     // n1 - n0
  logic signed [5:0] cnt_ext;
  logic signed [5:0] sum;
  logic [9:0]        pix_d;
  logic signed [4:0] cnt_d;
  logic signed [4:0] cnt_q;
  logic [1:0]        dtype2_q;
  logic [9:0]        ctlw2_q;
  logic [9:0]        auxw2_q;
  logic [9:0]        pixw2_q;

  // DC-balance decision and disparity update; non-pixel symbols clear the count
  always_comb begin
    n1      = popcount8(qm1_q[7:0]);
    n0      = 4'd8 - n1;
    diff    = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    cnt_ext = {cnt_q[4], cnt_q};
    if ((cnt_q == 5'sd0) || (n1 == n0)) begin
      pix_d = {~qm1_q[8], qm1_q[8], qm1_q[8] ? qm1_q[7:0] : ~qm1_q[7:0]};
      sum   = cnt_ext + (qm1_q[8] ? diff : -diff);
    end else if ((!cnt_q[4] && (n1 > n0)) || (cnt_q[4] && (n0 > n1))) begin
      pix_d = {1'b1, qm1_q[8], ~qm1_q[7:0]};
      sum   = cnt_ext + (qm1_q[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      pix_d = {1'b0, qm1_q[8], qm1_q[7:0]};
      sum   = cnt_ext + diff - (qm1_q[8] ? 6'sd0 : 6'sd2);
    end
    cnt_d = (dtype1_q == DT_PIX) ? sum[4:0] : 5'sd0;
  end

  // S2 registers: every candidate word plus the running disparity
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dtype2_q <= DT_CTRL;
      ctlw2_q  <= CTRL_WORDS[2'd0];
      auxw2_q  <= 10'd0;
      pixw2_q  <= 10'd0;
      cnt_q    <= 5'sd0;
    end else if (ce_i) begin
      dtype2_q <= dtype1_q;
      ctlw2_q  <= CTRL_WORDS[ctl1_q];
      auxw2_q  <= TERC4_WORDS[aux1_q];
      pixw2_q  <= pix_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------- S3 ----------------
  logic [9:0] sym;
  logic [9:0] word_d;
  logic [9:0] word_q;

  // Pick the symbol for this type and apply serialiser bit order
  always_comb begin
    case (dtype2_q)
      DT_GUARD: sym = GUARD_WORD;
      DT_CTRL:  sym = ctlw2_q;
      DT_AUX:   sym = auxw2_q;
      default:  sym = pixw2_q;
    endcase
    word_d = BIT_REVERSE ? bitrev10(sym) : sym;
  end

  // S3 output register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= RESET_WORD;
    end else if (ce_i) begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

`ifdef TMDS_DISP_MON_EN
  logic signed [4:0] disp_q;

  // Disparity snapshot kept in step with the S3 output
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_q <= 5'sd0;
    end else if (ce_i) begin
      disp_q <= cnt_q;
    end
  end

  assign disp_o = disp_q;
`endif

endmodule
`default_nettype wire

// File: rtl/tmds_encoder_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tmds_encoder_multi                                              |
// | Purpose  : NCHAN-lane TMDS encoder (pixel / control / TERC4 / guard) with  |
// |            a 3-strobe clock-enabled pipeline and pipeline-fill flag.       |
// | Options  : TMDS_DISP_MON_EN adds o_disp and sticky o_disp_err              |
// | Revision : 1.0  initial multi-lane release                                 |
// +----------------------------------------------------------------------------+
module tmds_encoder_multi
  import tmds_pkg::*;
#(
  parameter int NCHAN       = 3,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [1:0]            i_dtype,
  input  logic [2*NCHAN-1:0]    i_ctl,
  input  logic [4*NCHAN-1:0]    i_aux,
  input  logic [8*NCHAN-1:0]    i_data,
  output logic [10*NCHAN-1:0]   o_word,
  output logic                  o_valid
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [5*NCHAN-1:0]    o_disp,
  output logic                  o_disp_err
`endif
);

`ifdef TMDS_DISP_MON_EN
  logic [NCHAN-1:0] lane_big;
`endif

  for (genvar k = 0; k < NCHAN; k++) begin : g_lane
`ifdef TMDS_DISP_MON_EN
    logic signed [4:0] lane_disp;
`endif

    tmds_lane_enc #(
      .LANE        (k),
      .BIT_REVERSE (BIT_REVERSE)
    ) u_lane (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .ce_i    (i_ce),
      .dtype_i (i_dtype),
      .ctl_i   (i_ctl[2*k +: 2]),
      .aux_i   (i_aux[4*k +: 4]),
      .data_i  (i_data[8*k +: 8]),
      .word_o  (o_word[10*k +: 10])
`ifdef TMDS_DISP_MON_EN
      ,
      .disp_o  (lane_disp)
`endif
    );

`ifdef TMDS_DISP_MON_EN
    assign o_disp[5*k +: 5] = lane_disp;
    assign lane_big[k]      = (lane_disp > 5'sd9) || (lane_disp < -5'sd9);
`endif
  end

  logic [1:0] fill_q;

  // Count enable strobes since reset, saturating once the pipe is full
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fill_q <= 2'd0;
    end else if (i_ce && (fill_q != 2'd3)) begin
      fill_q <= fill_q + 2'd1;
    end
  end

  assign o_valid = (fill_q == 2'd3);

`ifdef TMDS_DISP_MON_EN
  logic err_q;

  // Sticky flag: any lane's disparity escaped the legal band
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else if (|lane_big) begin
      err_q <= 1'b1;
    end
  end

  assign o_disp_err = err_q;
`endif

endmodule
`default_nettype wire
